// File: rtl/serial_demux.sv
// serial_demux: 1-to-WIDTH LSB-first deserializer with a one-entry registered output.
// Latency: the word appears on dout/dout_valid the cycle after its last bit is presented.
// Backpressure: none toward din; a word completed while the output is full and not taken is dropped and sets overrun.
// Optional even-parity trailer bit per word: define SERIAL_DEMUX_PARITY_EN.
module serial_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun
`ifdef SERIAL_DEMUX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef SERIAL_DEMUX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(N);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic [CW-1:0]    slot;
  logic             complete;
`ifdef SERIAL_DEMUX_PARITY_EN
  logic             perr_q, perr_d;
`endif

  // Capture the incoming bit, advance the slot count and manage the output holding register.
  always_comb begin
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    dout_d   = dout_q;
    vld_d    = vld_q;
    ovr_d    = ovr_q;
    complete = 1'b0;
`ifdef SERIAL_DEMUX_PARITY_EN
    perr_d   = perr_q;
`endif
    // sof forces the current bit (if any) into slot 0.
    slot = sof ? '0 : cnt_q;

    if (din_valid) begin
      if (sof) begin
        sr_d = '0;
      end
      // Slots at WIDTH and beyond (the parity bit) are not stored.
      for (int i = 0; i < WIDTH; i++) begin
        if (slot == CW'(i)) begin
          sr_d[i] = din;
        end
      end
      if (slot == CW'(N - 1)) begin
        complete = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = slot + 1'b1;
      end
    end else if (sof) begin
      cnt_d = '0;
    end

    if (complete) begin
      if (!vld_q || dout_ready) begin
        dout_d = sr_d;
        vld_d  = 1'b1;
`ifdef SERIAL_DEMUX_PARITY_EN
        // Even parity: XOR over data plus the trailing parity bit must be zero.
        perr_d = ^{sr_d, din};
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && dout_ready) begin
      vld_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef SERIAL_DEMUX_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
`ifdef SERIAL_DEMUX_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign overrun    = ovr_q;
`ifdef SERIAL_DEMUX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_demux.sv
// Bench for serial_demux: directed bit streams, expected words queued at issue time,
// a negedge monitor pops and compares on every output handshake.
module tb_serial_demux;

  localparam int WIDTH = 8;
`ifdef SERIAL_DEMUX_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             sof = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready = 1'b1;
  logic             overrun;
  logic             perr_w;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH:0] expq[$];

  serial_demux #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
`ifdef SERIAL_DEMUX_PARITY_EN
    ,
    .parity_err (perr_w)
`endif
  );

`ifndef SERIAL_DEMUX_PARITY_EN
  assign perr_w = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted word must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && dout_valid && dout_ready) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL word: got unexpected %0h, expected no word", {perr_w, dout});
      end else begin
        check("word", 32'({perr_w, dout}), 32'(expq.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic d, input logic s);
    din       = d;
    din_valid = 1'b1;
    sof       = s;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = 1'b0;
  endtask

  // Sends one word LSB first (plus parity bit when enabled). flip inverts the parity bit,
  // so the expected parity_err equals flip.
  task automatic send_word(input logic [WIDTH-1:0] w, input logic s, input int gap_at,
                           input int gap_n, input logic flip, input logic push);
    logic p;
    logic b;
    p = (^w) ^ flip;
`ifdef SERIAL_DEMUX_PARITY_EN
    if (push) expq.push_back({flip, w});
`else
    if (push) expq.push_back({1'b0, w});
`endif
    for (int i = 0; i < NB; i++) begin
      if (i == gap_at) idle(gap_n);
      b = (i < WIDTH) ? w[i] : p;
      send_bit(b, s && (i == 0));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"}, 32'(dout), 32'h0);
    check({tag, "_valid"}, 32'(dout_valid), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_perr"}, 32'(perr_w), 32'h0);
  endtask

  initial begin
    // Reset state
    idle(2);
    check_zero("reset");
    reset = 1'b0;
    idle(1);
    check_zero("post_reset");

    // Basic word: bits 1,0,1,1,0,0,0,1 -> 8'h8D
    send_word(8'h8D, 1'b0, -1, 0, 1'b0, 1'b1);
    check("t1_valid", 32'(dout_valid), 32'h1);
    check("t1_dout", 32'(dout), 32'h8D);
    idle(1);
    check("t1_valid_one_cycle", 32'(dout_valid), 32'h0);
    check("t1_dout_retained", 32'(dout), 32'h8D);
    check("t1_overrun", 32'(overrun), 32'h0);

    // Idle gap of 3 cycles between bit 4 and bit 5
    send_word(8'h8D, 1'b0, 4, 3, 1'b0, 1'b1);
    check("t2_dout", 32'(dout), 32'h8D);
    idle(1);

    // Partial word of 3 bits, then sof restarts with 8'hA5
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_word(8'hA5, 1'b1, -1, 0, 1'b0, 1'b1);
    check("t3_dout", 32'(dout), 32'hA5);
    idle(1);

    // sof without a valid bit clears the count
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    sof = 1'b1;
    idle(1);
    sof = 1'b0;
    send_word(8'h5A, 1'b0, -1, 0, 1'b0, 1'b1);
    check("t_sof_idle_dout", 32'(dout), 32'h5A);
    idle(1);

    // Back-to-back words with consumer ready: both delivered, no overrun
    send_word(8'h0F, 1'b0, -1, 0, 1'b0, 1'b1);
    send_word(8'hF0, 1'b0, -1, 0, 1'b0, 1'b1);
    check("t_b2b_dout", 32'(dout), 32'hF0);
    check("t_b2b_overrun", 32'(overrun), 32'h0);
    idle(1);

    // Overrun: consumer stalled across two words
    dout_ready = 1'b0;
    send_word(8'h11, 1'b0, -1, 0, 1'b0, 1'b1);
    send_word(8'h22, 1'b0, -1, 0, 1'b0, 1'b0);
    check("t4_dout_held", 32'(dout), 32'h11);
    check("t4_valid", 32'(dout_valid), 32'h1);
    check("t4_overrun", 32'(overrun), 32'h1);
    idle(2);
    check("t4_dout_stable", 32'(dout), 32'h11);
    dout_ready = 1'b1;
    idle(1);
    dout_ready = 1'b0;
    check("t4_valid_dropped", 32'(dout_valid), 32'h0);
    check("t4_overrun_sticky", 32'(overrun), 32'h1);
    idle(2);
    check("t4_overrun_still", 32'(overrun), 32'h1);
    dout_ready = 1'b1;

    // Reset mid-word discards the partial word and clears overrun
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    reset = 1'b1;
    idle(1);
    check_zero("t5_in_reset");
    idle(1);
    reset = 1'b0;
    idle(1);
    check_zero("t5_after_reset");
    send_word(8'h3C, 1'b0, -1, 0, 1'b0, 1'b1);
    check("t5_dout", 32'(dout), 32'h3C);
    idle(1);

`ifdef SERIAL_DEMUX_PARITY_EN
    // 8'h07 with correct parity bit 1 -> no error; with parity bit 0 -> error
    send_word(8'h07, 1'b0, -1, 0, 1'b0, 1'b1);
    check("p_ok_dout", 32'(dout), 32'h07);
    check("p_ok_perr", 32'(perr_w), 32'h0);
    idle(1);
    send_word(8'h07, 1'b0, -1, 0, 1'b1, 1'b1);
    check("p_bad_dout", 32'(dout), 32'h07);
    check("p_bad_perr", 32'(perr_w), 32'h1);
    idle(1);
`endif

    idle(3);
    check("queue_empty", 32'(expq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
